selector_addr_sequencer: RTL and testbench
==========================================

// Module: selector_addr_sequencer
// PURPOSE
//  Upstream address generator for the 8-bit selector stage. Accepts burst commands
//  (base, count, stride) and emits one 8-bit address per handshake, driving the
//  selector's addr input so its one-hot output walks through the requested lines.
//  Supports wrap-around, early termination on overflow, and synchronous abort.
// PARAMETERS
//  ADDR_W   8   address width; must match the selector's address input
//  CNT_W    9   burst-count width; a burst is 1..2**ADDR_W addresses (256)
// PORTS
//  clk          in   1       single clock; all state updates on rising edge
//  rst_n        in   1       asynchronous reset, active low
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       sequencer can accept a command (high only in IDLE)
//  cmd_base     in   ADDR_W  first address of the burst
//  cmd_count    in   CNT_W   number of addresses; 0 is illegal
//  cmd_stride   in   ADDR_W  increment between addresses; 0 is legal (repeat)
//  cmd_wrap     in   1       1: wrap mod 2**ADDR_W; 0: overflow terminates burst
//  abort        in   1       synchronous abort, highest priority
//  addr         out  ADDR_W  current address to the selector
//  addr_valid   out  1       addr is valid
//  addr_ready   in   1       downstream consumed addr this cycle
//  addr_last    out  1       current addr is the final one of the burst
//  busy         out  1       state != IDLE
//  done_pulse   out  1       one-cycle pulse on normal burst completion
//  err_pulse    out  1       one-cycle pulse on illegal command or overflow
// BEHAVIOUR
//  - Reset: state=IDLE; addr=0, addr_valid=0, addr_last=0, busy=0, done_pulse=0,
//    err_pulse=0; cmd_ready=1 (decoded from IDLE). Internal regs cleared.
//  - States: IDLE, RUN, DONE. All outputs registered or decoded from state.
//  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready:
//    - cmd_count==0: err_pulse=1 next cycle, remain IDLE, no addr_valid.
//    - else: latch addr=cmd_base, remain=cmd_count, stride, wrap; go RUN.
//      addr_valid rises the cycle after acceptance (1-cycle latency).
//  - RUN: addr_valid=1; addr_last=(remain==1). addr, addr_last held stable while
//    addr_ready=0. On addr_valid&&addr_ready:
//    - remain==1: go DONE; addr_valid=0 next cycle.
//    - else: sum = {1'b0,addr}+stride (ADDR_W+1 bits).
//      - sum carry=1 and wrap=0: err_pulse=1, go IDLE, addr_valid=0 next cycle.
//      - otherwise: addr=sum[ADDR_W-1:0], remain=remain-1; stay RUN.
//  - Throughput: one address per cycle while addr_ready held high.
//  - DONE: lasts exactly one cycle; done_pulse=1, addr_valid=0, cmd_ready=0;
//    then IDLE. A new command is accepted no earlier than the following cycle.
//  - abort=1 in any state: next cycle state=IDLE, addr_valid=0, addr_last=0;
//    no done_pulse, no err_pulse. Overrides a simultaneous cmd accept or handshake.
//  - Async reset mid-burst: outputs return to reset values immediately;
//    the burst is discarded with no pulse.
//  - done_pulse and err_pulse are never high in the same cycle.
//  - addr retains its last value when addr_valid=0.
// TESTING
//  1 base=0x10,count=4,stride=1,ready=1 -> addr 0x10,0x11,0x12,0x13 on
//    consecutive cycles; addr_last only on 0x13; done_pulse the cycle after.
//  2 base=0xFE,count=4,stride=1,wrap=1 -> 0xFE,0xFF,0x00,0x01; done_pulse=1,
//    err_pulse=0.
//  3 Same with wrap=0 -> 0xFE,0xFF, then err_pulse=1, no done_pulse, IDLE,
//    cmd_ready=1.
//  4 base=0x00,count=3,stride=0x40 with addr_ready toggled 1/0 -> 0x00,0x40,0x80,
//    each held stable under stall; no skipped or duplicated handshake.
//  5 count=0 -> err_pulse 1 cycle, addr_valid never high;
//    count=256,base=0,stride=1 -> all 256 addresses in order; each selector
//    output is exactly one-hot.
//  6 abort asserted on the 3rd handshake of a count=8 burst -> addr_valid=0 next
//    cycle; IDLE; no pulses; next command starts cleanly at its base.

Source files
------------

// File: rtl/selector_addr_sequencer_if.sv
// Command and address channels between the burst address sequencer and the
// environment around it. The sequencer takes the slave view (it receives burst
// commands); whatever issues commands and consumes addresses takes the master view.
interface selector_addr_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 9
);
    // Command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base;
    logic [CNT_W-1:0]  cmd_count;
    logic [ADDR_W-1:0] cmd_stride;
    logic              cmd_wrap;
    logic              abort;

    // Address channel toward the selector
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic              addr_ready;
    logic              addr_last;

    // Status
    logic              busy;
    logic              done_pulse;
    logic              err_pulse;

    modport slave (
        input  cmd_valid, cmd_base, cmd_count, cmd_stride, cmd_wrap, abort, addr_ready,
        output cmd_ready, addr, addr_valid, addr_last, busy, done_pulse, err_pulse
    );

    modport master (
        output cmd_valid, cmd_base, cmd_count, cmd_stride, cmd_wrap, abort, addr_ready,
        input  cmd_ready, addr, addr_valid, addr_last, busy, done_pulse, err_pulse
    );
endinterface

// File: rtl/selector_addr_sequencer.sv
// Burst address generator feeding the 8-bit selector stage. A command
// (base, count, stride, wrap) produces count addresses, one per handshake,
// starting at base and stepping by stride. Without wrap, a step that carries
// out of the address range ends the burst with an error pulse. Abort returns
// to idle silently from any state.
module selector_addr_sequencer #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    selector_addr_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic              wrap_q, wrap_d;
    logic              err_q, err_d;

    // Next address with the carry bit kept, so overflow is visible.
    logic [ADDR_W:0]   sum;
    assign sum = {1'b0, addr_q} + {1'b0, stride_q};

    // State and burst registers; everything clears on reset.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed by the combinational block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            stride_q <= '0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            stride_q <= stride_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
        end
    end

    // Next-state and next-register logic; abort overrides everything.
    // NOTE: every target gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        stride_d = stride_q;
        wrap_d   = wrap_q;
        err_d    = 1'b0;

        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (bus.cmd_count == '0) begin
                            err_d = 1'b1;
                        end else begin
                            addr_d   = bus.cmd_base;
                            remain_d = bus.cmd_count;
                            stride_d = bus.cmd_stride;
                            wrap_d   = bus.cmd_wrap;
                            state_d  = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.addr_ready) begin
                        if (remain_q == CNT_W'(1)) begin
                            state_d = S_DONE;
                        end else if (sum[ADDR_W] && !wrap_q) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            addr_d   = sum[ADDR_W-1:0];
                            remain_d = remain_q - CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are either registers or decodes of the current state.
    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.addr       = addr_q;
    assign bus.addr_valid = (state_q == S_RUN);
    assign bus.addr_last  = (state_q == S_RUN) && (remain_q == CNT_W'(1));
    assign bus.done_pulse = (state_q == S_DONE);
    assign bus.err_pulse  = err_q;

endmodule

// File: tb/tb_selector_addr_sequencer.sv
// Self-checking bench for selector_addr_sequencer: a transaction-level model
// (queue of addresses still owed for the current burst) checked against the
// DUT every cycle, directed scenarios with literal expectations, and a
// randomized phase with random stalls and aborts.
module tb_selector_addr_sequencer;

    logic clk;
    logic rst_n;

    selector_addr_sequencer_if #(.ADDR_W(8), .CNT_W(9)) bus ();

    selector_addr_sequencer #(.ADDR_W(8), .CNT_W(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stimulus controls
    logic abort_man;
    logic abort_rnd;
    bit   abort_rnd_en;
    int   ready_mode;   // 0: always ready, 1: toggle, 2: random

    assign bus.abort = abort_man | abort_rnd;

    // ---------------- behavioural model ----------------
    logic [7:0] m_q[$];     // addresses still to be handed out, front = current
    logic [7:0] m_addr;     // address shown on the bus
    bit         m_trunc;    // burst ends in overflow rather than completion
    bit         m_done;
    bit         m_err;

    task automatic model_reset();
        m_q.delete();
        m_addr  = 8'h00;
        m_trunc = 1'b0;
        m_done  = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_build(input logic [7:0] base, input int cnt,
                               input logic [7:0] stride, input logic wrap);
        int v;
        m_trunc = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            v = int'(base) + i * int'(stride);
            if (!wrap && v > 255) begin
                m_trunc = 1'b1;
                break;
            end
            m_q.push_back(8'(v));
        end
        m_addr = m_q[0];
    endtask

    task automatic model_step();
        bit nd = 1'b0;
        bit ne = 1'b0;
        if (bus.abort) begin
            m_q.delete();
            m_trunc = 1'b0;
        end else if (m_done) begin
            // completion cycle: nothing accepted
        end else if (m_q.size() == 0) begin
            if (bus.cmd_valid) begin
                if (bus.cmd_count == 9'd0) ne = 1'b1;
                else model_build(bus.cmd_base, int'(bus.cmd_count), bus.cmd_stride, bus.cmd_wrap);
            end
        end else if (bus.addr_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() != 0) begin
                m_addr = m_q[0];
            end else if (m_trunc) begin
                ne = 1'b1;
                m_trunc = 1'b0;
            end else begin
                nd = 1'b1;
            end
        end
        m_done = nd;
        m_err  = ne;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Compare process: every cycle out of reset, all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("addr_valid", 32'(bus.addr_valid), 32'(m_q.size() != 0));
                check("addr",       32'(bus.addr),       32'(m_addr));
                check("addr_last",  32'(bus.addr_last),  32'(m_q.size() == 1 && !m_trunc));
                check("cmd_ready",  32'(bus.cmd_ready),  32'(m_q.size() == 0 && !m_done));
                check("busy",       32'(bus.busy),       32'(m_q.size() != 0 || m_done));
                check("done_pulse", 32'(bus.done_pulse), 32'(m_done));
                check("err_pulse",  32'(bus.err_pulse),  32'(m_err));
            end
        end
    end

    // Monitor: records handshaked addresses and counts pulses.
    logic [7:0] cap[$];
    bit         cap_last[$];
    int         done_cnt = 0;
    int         err_cnt  = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.addr_valid && bus.addr_ready) begin
                    cap.push_back(bus.addr);
                    cap_last.push_back(bus.addr_last);
                end
                if (bus.done_pulse) done_cnt++;
                if (bus.err_pulse)  err_cnt++;
            end
        end
    end

    // Ready / random-abort driver, updated just after each rising edge.
    initial begin
        bus.addr_ready = 1'b0;
        abort_rnd      = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.addr_ready = 1'b1;
                1:       bus.addr_ready = ~bus.addr_ready;
                default: bus.addr_ready = 1'($urandom_range(0, 1));
            endcase
            abort_rnd = abort_rnd_en && ($urandom_range(0, 39) == 0);
        end
    end

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_cmd(input logic [7:0] base, input logic [8:0] cnt,
                            input logic [7:0] stride, input logic wrap);
        bit accepted = 1'b0;
        bus.cmd_base   = base;
        bus.cmd_count  = cnt;
        bus.cmd_stride = stride;
        bus.cmd_wrap   = wrap;
        bus.cmd_valid  = 1'b1;
        for (int i = 0; i < 2000 && !accepted; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) accepted = 1'b1;
        end
        if (!accepted) check("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 3000 && !idle; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) idle = 1'b1;
        end
        if (!idle) check("idle_timeout", 32'd0, 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_capture();
        cap.delete();
        cap_last.delete();
    endtask

    // ---------------- main sequence ----------------
    int d0, e0;
    logic [7:0] e_t1[4];
    logic [7:0] e_t2[4];
    logic [7:0] e_t4[3];
    logic [7:0] e_t6[3];
    bit         order_ok;

    initial begin
        e_t1 = '{8'h10, 8'h11, 8'h12, 8'h13};
        e_t2 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        e_t4 = '{8'h00, 8'h40, 8'h80};
        e_t6 = '{8'h30, 8'h35, 8'h3A};

        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_base   = '0;
        bus.cmd_count  = '0;
        bus.cmd_stride = '0;
        bus.cmd_wrap   = 1'b0;
        abort_man      = 1'b0;
        abort_rnd_en   = 1'b0;
        ready_mode     = 0;

        // Reset state
        #7;
        check("rst_addr",       32'(bus.addr),       32'h00);
        check("rst_addr_valid", 32'(bus.addr_valid), 32'd0);
        check("rst_addr_last",  32'(bus.addr_last),  32'd0);
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_cmd_ready",  32'(bus.cmd_ready),  32'd1);
        check("rst_done",       32'(bus.done_pulse), 32'd0);
        check("rst_err",        32'(bus.err_pulse),  32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: simple incrementing burst
        clear_capture(); d0 = done_cnt; e0 = err_cnt;
        send_cmd(8'h10, 9'd4, 8'h01, 1'b0);
        wait_idle();
        check("t1_len", 32'(cap.size()), 32'd4);
        for (int i = 0; i < 4 && i < cap.size(); i++) begin
            check("t1_addr", 32'(cap[i]), 32'(e_t1[i]));
            check("t1_last", 32'(cap_last[i]), 32'(i == 3));
        end
        check("t1_done", 32'(done_cnt - d0), 32'd1);
        check("t1_err",  32'(err_cnt - e0),  32'd0);

        // 2: wrap across the top of the address range
        clear_capture(); d0 = done_cnt; e0 = err_cnt;
        send_cmd(8'hFE, 9'd4, 8'h01, 1'b1);
        wait_idle();
        check("t2_len", 32'(cap.size()), 32'd4);
        for (int i = 0; i < 4 && i < cap.size(); i++)
            check("t2_addr", 32'(cap[i]), 32'(e_t2[i]));
        check("t2_done", 32'(done_cnt - d0), 32'd1);
        check("t2_err",  32'(err_cnt - e0),  32'd0);

        // 3: same without wrap terminates on overflow
        clear_capture(); d0 = done_cnt; e0 = err_cnt;
        send_cmd(8'hFE, 9'd4, 8'h01, 1'b0);
        wait_idle();
        check("t3_len", 32'(cap.size()), 32'd2);
        check("t3_done", 32'(done_cnt - d0), 32'd0);
        check("t3_err",  32'(err_cnt - e0),  32'd1);
        check("t3_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // 4: large stride with a toggling consumer
        ready_mode = 1;
        clear_capture(); d0 = done_cnt;
        send_cmd(8'h00, 9'd3, 8'h40, 1'b0);
        wait_idle();
        check("t4_len", 32'(cap.size()), 32'd3);
        for (int i = 0; i < 3 && i < cap.size(); i++)
            check("t4_addr", 32'(cap[i]), 32'(e_t4[i]));
        check("t4_done", 32'(done_cnt - d0), 32'd1);
        ready_mode = 0;

        // 5a: zero count is rejected
        clear_capture(); d0 = done_cnt; e0 = err_cnt;
        send_cmd(8'h55, 9'd0, 8'h01, 1'b0);
        wait_idle();
        check("t5_zero_len", 32'(cap.size()), 32'd0);
        check("t5_zero_err", 32'(err_cnt - e0), 32'd1);
        check("t5_zero_done", 32'(done_cnt - d0), 32'd0);

        // 5b: full 256-address burst
        clear_capture(); d0 = done_cnt; e0 = err_cnt;
        send_cmd(8'h00, 9'd256, 8'h01, 1'b0);
        wait_idle();
        check("t5_full_len", 32'(cap.size()), 32'd256);
        order_ok = (cap.size() == 256);
        for (int i = 0; i < cap.size(); i++)
            if (cap[i] != 8'(i)) order_ok = 1'b0;
        check("t5_full_order", 32'(order_ok), 32'd1);
        check("t5_full_done", 32'(done_cnt - d0), 32'd1);
        check("t5_full_err",  32'(err_cnt - e0),  32'd0);

        // 6: abort on the third handshake, then a clean new burst
        clear_capture(); d0 = done_cnt; e0 = err_cnt;
        send_cmd(8'h30, 9'd8, 8'h05, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort_man = 1'b1;
        @(posedge clk); #1;
        abort_man = 1'b0;
        @(negedge clk);
        check("t6_valid_after_abort", 32'(bus.addr_valid), 32'd0);
        check("t6_busy_after_abort",  32'(bus.busy),       32'd0);
        wait_idle();
        check("t6_len", 32'(cap.size()), 32'd3);
        for (int i = 0; i < 3 && i < cap.size(); i++)
            check("t6_addr", 32'(cap[i]), 32'(e_t6[i]));
        check("t6_done", 32'(done_cnt - d0), 32'd0);
        check("t6_err",  32'(err_cnt - e0),  32'd0);
        clear_capture();
        send_cmd(8'h77, 9'd2, 8'h01, 1'b0);
        wait_idle();
        check("t6_next_len", 32'(cap.size()), 32'd2);
        if (cap.size() > 0) check("t6_next_base", 32'(cap[0]), 32'h77);

        // Asynchronous reset in the middle of a burst
        d0 = done_cnt; e0 = err_cnt;
        send_cmd(8'h20, 9'd10, 8'h01, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_addr_valid", 32'(bus.addr_valid), 32'd0);
        check("arst_addr",       32'(bus.addr),       32'h00);
        check("arst_busy",       32'(bus.busy),       32'd0);
        check("arst_cmd_ready",  32'(bus.cmd_ready),  32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("arst_no_done", 32'(done_cnt - d0), 32'd0);
        check("arst_no_err",  32'(err_cnt - e0),  32'd0);

        // Randomized phase: back-to-back commands, random stalls and aborts
        abort_rnd_en = 1'b1;
        for (int n = 0; n < 60; n++) begin
            logic [8:0] cnt;
            ready_mode = $urandom_range(0, 2);
            case ($urandom_range(0, 9))
                0:       cnt = 9'd0;
                1:       cnt = 9'($urandom_range(200, 256));
                default: cnt = 9'($urandom_range(1, 12));
            endcase
            send_cmd(8'($urandom_range(0, 255)), cnt,
                     ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 255)),
                     1'($urandom_range(0, 1)));
        end
        abort_rnd_en = 1'b0;
        ready_mode   = 0;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
